// File: rtl/wisc_mem_arbiter_if.sv
// rtl/wisc_mem_arbiter_if.sv - cache-side and memory-side signals of the unified memory arbiter
interface wisc_mem_arbiter_if #(
  parameter int ARCH_WIDTH     = 16,
  parameter int WORDS_PER_LINE = 8
);
  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  logic                  i_req;
  logic [ARCH_WIDTH-1:0] i_addr;
  logic                  i_grant;
  logic                  i_fill_valid;
  logic                  i_done;
  logic                  d_req;
  logic                  d_we;
  logic [ARCH_WIDTH-1:0] d_addr;
  logic [ARCH_WIDTH-1:0] d_wdata;
  logic                  d_grant;
  logic                  d_fill_valid;
  logic                  d_done;
  logic [ARCH_WIDTH-1:0] fill_data;
  logic [IDX_W-1:0]      fill_idx;
  logic                  mem_en;
  logic                  mem_wr;
  logic [ARCH_WIDTH-1:0] mem_addr;
  logic [ARCH_WIDTH-1:0] mem_wdata;
  logic [ARCH_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rvalid,
    output i_grant, i_fill_valid, i_done, d_grant, d_fill_valid, d_done,
           fill_data, fill_idx, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rvalid,
    input  i_grant, i_fill_valid, i_done, d_grant, d_fill_valid, d_done,
           fill_data, fill_idx, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/wisc_mem_arbiter.sv
// rtl/wisc_mem_arbiter.sv - shares the unified memory between I-cache and D-cache miss paths
// Line fills issue pipelined reads and stream words back; D stores are single write-through words.
module wisc_mem_arbiter #(
  parameter int ARCH_WIDTH     = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter int MEM_LATENCY    = 4
) (
  input logic              clk,
  input logic              rst,
  wisc_mem_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [ARCH_WIDTH-1:0] LINE_MASK = ~ARCH_WIDTH'(2 * WORDS_PER_LINE - 1);
  localparam logic [ARCH_WIDTH-1:0] WORD_MASK = ~ARCH_WIDTH'(1);

  if (WORDS_PER_LINE < 2 || (WORDS_PER_LINE & (WORDS_PER_LINE - 1)) != 0 || MEM_LATENCY < 1) begin : g_bad_param
    $error("wisc_mem_arbiter: WORDS_PER_LINE must be a power of 2 >= 2 and MEM_LATENCY >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WRITE} state_t;

  state_t                state, stateNext;
  logic                  ownerD;
  logic [ARCH_WIDTH-1:0] base;
  logic [ARCH_WIDTH-1:0] wAddr;
  logic [ARCH_WIDTH-1:0] wData;
  logic [IDX_W-1:0]      issueCnt;
  logic [IDX_W-1:0]      retCnt;
  logic [1:0]            starve;
  logic                  grantI, grantD;
  logic                  rvalidLive, lastRet;

  // D wins ties unless it has already beaten a waiting I twice in a row.
  always_comb begin
    grantI = 1'b0;
    grantD = 1'b0;
    if (state == IDLE && !rst) begin
      if (bus.i_req && (!bus.d_req || starve == 2'd2)) grantI = 1'b1;
      else if (bus.d_req)                              grantD = 1'b1;
    end
  end

  assign rvalidLive = (state == ISSUE || state == DRAIN) && bus.mem_rvalid;
  assign lastRet    = rvalidLive && (retCnt == LAST_IDX);

  always_comb begin
    stateNext        = state;
    bus.i_grant      = grantI;
    bus.d_grant      = grantD;
    bus.i_fill_valid = 1'b0;
    bus.d_fill_valid = 1'b0;
    bus.i_done       = 1'b0;
    bus.d_done       = 1'b0;
    bus.fill_data    = '0;
    bus.fill_idx     = '0;
    bus.mem_en       = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    case (state)
      IDLE: begin
        if (grantI)      stateNext = ISSUE;
        else if (grantD) stateNext = bus.d_we ? WRITE : ISSUE;
      end
      ISSUE: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = base + ARCH_WIDTH'({issueCnt, 1'b0});
        if (issueCnt == LAST_IDX) stateNext = DRAIN;
      end
      DRAIN: begin
        if (lastRet) stateNext = IDLE;
      end
      WRITE: begin
        bus.mem_en    = 1'b1;
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = wAddr;
        bus.mem_wdata = wData;
        bus.d_done    = 1'b1;
        stateNext     = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // Returns overlap the tail of ISSUE when the memory latency is shorter than a line.
    if (rvalidLive) begin
      bus.fill_data = bus.mem_rdata;
      bus.fill_idx  = retCnt;
      if (ownerD) begin
        bus.d_fill_valid = 1'b1;
        bus.d_done       = lastRet;
      end else begin
        bus.i_fill_valid = 1'b1;
        bus.i_done       = lastRet;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ownerD   <= 1'b0;
      base     <= '0;
      wAddr    <= '0;
      wData    <= '0;
      issueCnt <= '0;
      retCnt   <= '0;
      starve   <= '0;
    end else begin
      state <= stateNext;
      if (grantI || grantD) begin
        ownerD   <= grantD;
        base     <= (grantD ? bus.d_addr : bus.i_addr) & LINE_MASK;
        wAddr    <= bus.d_addr & WORD_MASK;
        wData    <= bus.d_wdata;
        issueCnt <= '0;
        retCnt   <= '0;
      end else begin
        if (state == ISSUE) issueCnt <= issueCnt + 1'b1;
        if (rvalidLive)     retCnt   <= retCnt + 1'b1;
      end
      if (grantI)                   starve <= '0;
      else if (grantD && bus.i_req) starve <= starve + 2'd1;
    end
  end
endmodule

// File: tb/tb_wisc_mem_arbiter.sv
// tb/tb_wisc_mem_arbiter.sv - directed self-checking bench for wisc_mem_arbiter
module tb_wisc_mem_arbiter;
  localparam int L = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCmp = 0;
  int   nBad = 0;

  always #5 clk = ~clk;

  wisc_mem_arbiter_if #(.ARCH_WIDTH(16), .WORDS_PER_LINE(8)) bus ();

  wisc_mem_arbiter #(.ARCH_WIDTH(16), .WORDS_PER_LINE(8), .MEM_LATENCY(L)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Memory model: fixed-latency read pipeline, data = address ^ 0x5A5A.
  logic [L-1:0] pv = '0;
  logic [15:0]  pa [L];
  logic         strayV = 1'b0;
  logic [15:0]  strayD = '0;

  always @(posedge clk) begin
    pv    <= {pv[L-2:0], (bus.mem_en === 1'b1) && (bus.mem_wr === 1'b0)};
    pa[0] <= bus.mem_addr;
    for (int i = 1; i < L; i++) pa[i] <= pa[i-1];
  end

  assign bus.mem_rvalid = pv[L-1] | strayV;
  assign bus.mem_rdata  = strayV ? strayD : (pa[L-1] ^ 16'h5A5A);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chkIdleOutputs(input string tag);
    chk({tag, " i_grant"}, bus.i_grant, 0);
    chk({tag, " d_grant"}, bus.d_grant, 0);
    chk({tag, " mem_en"}, bus.mem_en, 0);
    chk({tag, " mem_addr"}, bus.mem_addr, 0);
    chk({tag, " mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, " i_fill_valid"}, bus.i_fill_valid, 0);
    chk({tag, " d_fill_valid"}, bus.d_fill_valid, 0);
    chk({tag, " i_done"}, bus.i_done, 0);
    chk({tag, " d_done"}, bus.d_done, 0);
  endtask

  // Checks cycles T+1..T+12 of a line fill granted at T; drops owner req at done.
  task automatic fillSeq(input bit isD, input logic [15:0] base, input string nm);
    logic [15:0] a;
    bit fv;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (k == 12) begin
        if (isD) bus.d_req = 1'b0;
        else     bus.i_req = 1'b0;
      end
      #1;
      chk($sformatf("%s mem_en k%0d", nm, k), bus.mem_en, (k <= 8));
      if (k <= 8) begin
        a = base + 16'(2 * (k - 1));
        chk($sformatf("%s mem_addr k%0d", nm, k), bus.mem_addr, a);
        chk($sformatf("%s mem_wr k%0d", nm, k), bus.mem_wr, 0);
      end
      fv = (k >= 5);
      chk($sformatf("%s own_fv k%0d", nm, k), isD ? bus.d_fill_valid : bus.i_fill_valid, fv);
      chk($sformatf("%s oth_fv k%0d", nm, k), isD ? bus.i_fill_valid : bus.d_fill_valid, 0);
      if (fv) begin
        a = base + 16'(2 * (k - 5));
        chk($sformatf("%s fill_idx k%0d", nm, k), bus.fill_idx, k - 5);
        chk($sformatf("%s fill_data k%0d", nm, k), bus.fill_data, a ^ 16'h5A5A);
      end
      chk($sformatf("%s done k%0d", nm, k), isD ? bus.d_done : bus.i_done, (k == 12));
    end
  endtask

  initial begin
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset state
    repeat (6) cyc();
    #1;
    chkIdleOutputs("reset");
    cyc();
    rst = 1'b0;

    // 1: I line fill
    cyc();
    bus.i_req = 1; bus.i_addr = 16'h1234;
    #1;
    chk("t1 i_grant", bus.i_grant, 1);
    chk("t1 d_grant", bus.d_grant, 0);
    fillSeq(1'b0, 16'h1230, "t1");
    cyc(); #1;
    chkIdleOutputs("t1 after");

    // 2: simultaneous requests, D wins the tie
    cyc();
    bus.i_req = 1; bus.i_addr = 16'h0500;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0047;
    #1;
    chk("t2 d_grant", bus.d_grant, 1);
    chk("t2 i_grant", bus.i_grant, 0);
    fillSeq(1'b1, 16'h0040, "t2d");
    cyc(); #1;
    chk("t2 i_grant later", bus.i_grant, 1);
    chk("t2 d_grant later", bus.d_grant, 0);
    fillSeq(1'b0, 16'h0500, "t2i");

    // 3: back-to-back stores against a waiting I -> D, D, I
    cyc();
    bus.i_req = 1; bus.i_addr = 16'h0A00;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0010; bus.d_wdata = 16'h1111;
    #1;
    chk("t3 d_grant1", bus.d_grant, 1);
    chk("t3 i_grant1", bus.i_grant, 0);
    cyc(); #1;
    chk("t3 d_done1", bus.d_done, 1);
    chk("t3 mem_addr1", bus.mem_addr, 16'h0010);
    cyc();
    bus.d_addr = 16'h0012; bus.d_wdata = 16'h2222;
    #1;
    chk("t3 d_grant2", bus.d_grant, 1);
    chk("t3 i_grant2", bus.i_grant, 0);
    cyc(); #1;
    chk("t3 mem_wdata2", bus.mem_wdata, 16'h2222);
    cyc(); #1;
    chk("t3 i_grant3", bus.i_grant, 1);
    chk("t3 d_grant3", bus.d_grant, 0);
    fillSeq(1'b0, 16'h0A00, "t3i");
    cyc();
    bus.d_req = 0;
    #1;
    chkIdleOutputs("t3 after");

    // 4: single store, word-aligned address
    cyc();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0101; bus.d_wdata = 16'hBEEF;
    #1;
    chk("t4 d_grant", bus.d_grant, 1);
    cyc();
    bus.d_req = 0;
    #1;
    chk("t4 mem_en", bus.mem_en, 1);
    chk("t4 mem_wr", bus.mem_wr, 1);
    chk("t4 mem_addr", bus.mem_addr, 16'h0100);
    chk("t4 mem_wdata", bus.mem_wdata, 16'hBEEF);
    chk("t4 d_done", bus.d_done, 1);
    cyc(); #1;
    chkIdleOutputs("t4 after");

    // 5: reset in the middle of a fill
    cyc();
    bus.i_req = 1; bus.i_addr = 16'h0200; bus.d_we = 0;
    #1;
    chk("t5 i_grant", bus.i_grant, 1);
    repeat (5) cyc();
    cyc();
    rst = 1'b1; bus.i_req = 0;
    cyc();
    rst = 1'b0;
    #1;
    chkIdleOutputs("t5 post-reset");
    for (int k = 0; k < 5; k++) begin
      cyc(); #1;
      chk($sformatf("t5 late i_fill_valid %0d", k), bus.i_fill_valid, 0);
      chk($sformatf("t5 late i_done %0d", k), bus.i_done, 0);
    end

    // 6: top-of-memory line, then stray rvalid in IDLE
    cyc();
    bus.i_req = 1; bus.i_addr = 16'hFFFF;
    #1;
    chk("t6 i_grant", bus.i_grant, 1);
    fillSeq(1'b0, 16'hFFF0, "t6");
    cyc();
    strayV = 1; strayD = 16'h1357;
    #1;
    chk("t6 stray i_fill_valid", bus.i_fill_valid, 0);
    chk("t6 stray d_fill_valid", bus.d_fill_valid, 0);
    chk("t6 stray fill_data", bus.fill_data, 0);
    cyc();
    strayV = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
